// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the parity_frame_rx serial receiver: FSM state
// encoding and serial line levels.
package parity_frame_rx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_frame_rx_if.sv
// Serial input plus valid/ready word output of parity_frame_rx.
// The master modport is the receiver side; the slave modport is the line driver and consumer.
interface parity_frame_rx_if #(
    parameter int WIDTH = 8
);
    import parity_frame_rx_pkg::*;

    logic             bit_en;
    logic             bit_in;
    logic [WIDTH-1:0] data_out;
    logic             parity_out;
    logic             parity_ok;
    logic             frame_err;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;

    modport master (
        input  bit_en, bit_in, out_ready,
        output data_out, parity_out, parity_ok, frame_err, out_valid, overrun
    );

    modport slave (
        output bit_en, bit_in, out_ready,
        input  data_out, parity_out, parity_ok, frame_err, out_valid, overrun
    );

endinterface

// File: rtl/parity_frame_rx_checker.sv
// Even-parity checker: parity_ok is 1 when the data bits XORed with the
// parity bit give 0.
module parity_checker #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             parity,
    output logic             parity_ok
);

    assign parity_ok = ~(^data ^ parity);

endmodule

// File: rtl/parity_frame_rx.sv
// Deserialises start/data/parity/stop frames from a bit_en-qualified serial
// line into a held output word with a valid/ready handshake.
module parity_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    parity_frame_rx_if.master bus
);
    import parity_frame_rx_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shift;
    logic             parity_bit;
    logic             stop_edge;
    logic             reg_free;

    assign stop_edge = bus.bit_en && (state == ST_STOP);
    // Accepting the held word on the same edge frees the register for a new load.
    assign reg_free  = !bus.out_valid || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
        end else if (bus.bit_en) begin
            case (state)
                ST_IDLE: begin
                    if (bus.bit_in == START_BIT) begin
                        state <= ST_DATA;
                        count <= '0;
                    end
                end
                ST_DATA: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (count == CW'(i)) shift[i] <= bus.bit_in;
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= ST_PARITY;
                end
                ST_PARITY: begin
                    parity_bit <= bus.bit_in;
                    state      <= ST_STOP;
                end
                ST_STOP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out   <= '0;
            bus.parity_out <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
            if (stop_edge) begin
                if (reg_free) begin
                    bus.data_out   <= shift;
                    bus.parity_out <= parity_bit;
                    bus.frame_err  <= (bus.bit_in != STOP_BIT);
                    bus.out_valid  <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;
                end
            end
        end
    end

    parity_checker #(.WIDTH(WIDTH)) u_checker (
        .data      (bus.data_out),
        .parity    (bus.parity_out),
        .parity_ok (bus.parity_ok)
    );

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomised scoreboard bench for parity_frame_rx: a transaction-level model
// queues expected words and a negedge monitor compares them on delivery.
module tb_parity_frame_rx;
    import parity_frame_rx_pkg::*;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             parity;
        logic             frame_err;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    parity_frame_rx_if #(.WIDTH(WIDTH)) bus ();

    parity_frame_rx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    word_t expQ[$];
    word_t pendingWord;
    logic  stopNow    = 1'b0;
    logic  modelValid = 1'b0;
    logic  expOverrun = 1'b0;
    logic  randReady  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic sendBit(input logic b, input int gap, input logic isStop);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            bus.bit_en = 1'b0;
            bus.bit_in = 1'($urandom_range(0, 1));
            stopNow    = 1'b0;
            if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        bus.bit_en = 1'b1;
        bus.bit_in = b;
        stopNow    = isStop;
        if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic p, input logic s,
                                 input int gap, input int idle);
        for (int k = 0; k < idle; k++) sendBit(IDLE_LEVEL, gap, 1'b0);
        sendBit(START_BIT, gap, 1'b0);
        for (int i = 0; i < WIDTH; i++) sendBit(d[i], gap, 1'b0);
        sendBit(p, gap, 1'b0);
        pendingWord = '{data: d, parity: p, frame_err: (s != STOP_BIT)};
        sendBit(s, gap, 1'b1);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) sendBit(IDLE_LEVEL, 0, 1'b0);
    endtask

    // Reference model: one output slot, delivered in order, dropped frames raise overrun.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                modelValid = 1'b0;
                expOverrun = 1'b0;
                expQ.delete();
            end else begin
                logic slotFree;
                slotFree = !modelValid || bus.out_ready;
                if (modelValid && bus.out_ready) modelValid = 1'b0;
                if (stopNow) begin
                    if (slotFree) begin
                        expQ.push_back(pendingWord);
                        modelValid = 1'b1;
                    end else begin
                        expOverrun = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("out_valid", 32'(bus.out_valid), 32'(modelValid));
                checkOutput("overrun", 32'(bus.overrun), 32'(expOverrun));
                if (bus.out_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected word", 32'(bus.data_out), 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("data_out", 32'(bus.data_out), 32'(expQ[0].data));
                        checkOutput("parity_out", 32'(bus.parity_out), 32'(expQ[0].parity));
                        checkOutput("parity_ok", 32'(bus.parity_ok),
                                    32'(($countones({expQ[0].data, expQ[0].parity}) % 2) == 0));
                        checkOutput("frame_err", 32'(bus.frame_err), 32'(expQ[0].frame_err));
                        if (bus.out_ready) void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.bit_en    = 1'b0;
        bus.bit_in    = IDLE_LEVEL;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset data_out", 32'(bus.data_out), 32'h0);
        checkOutput("reset parity_out", 32'(bus.parity_out), 32'h0);
        checkOutput("reset parity_ok", 32'(bus.parity_ok), 32'h1);
        checkOutput("reset frame_err", 32'(bus.frame_err), 32'h0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("reset overrun", 32'(bus.overrun), 32'h0);

        $display("[TB] basic, bad parity and bad stop frames");
        applyStimulus(8'h01, 1'b1, 1'b1, 0, 0);
        idleCycles(3);
        applyStimulus(8'hF0, 1'b1, 1'b1, 0, 0);
        applyStimulus(8'hF0, 1'b0, 1'b1, 0, 0);
        idleCycles(3);
        applyStimulus(8'hA5, 1'b0, 1'b0, 0, 0);
        idleCycles(3);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(8'h11, 1'b0, 1'b1, 0, 0);
        applyStimulus(8'h22, 1'b0, 1'b1, 0, 0);
        idleCycles(4);
        bus.out_ready = 1'b1;
        idleCycles(4);

        $display("[TB] gapped input");
        applyStimulus(8'h01, 1'b1, 1'b1, 3, 2);
        idleCycles(3);

        $display("[TB] reset mid-frame");
        sendBit(START_BIT, 0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'($urandom_range(0, 1)), 0, 1'b0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.bit_en = 1'b1;
        bus.bit_in = 1'b0;
        stopNow    = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.bit_in = IDLE_LEVEL;
        @(negedge clk);
        checkOutput("post-reset out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("post-reset overrun", 32'(bus.overrun), 32'h0);
        applyStimulus(8'h3C, 1'b0, 1'b1, 0, 0);
        idleCycles(3);

        $display("[TB] randomised frames");
        randReady = 1'b1;
        for (int n = 0; n < 150; n++) begin
            applyStimulus(WIDTH'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        randReady = 1'b0;
        bus.out_ready = 1'b1;
        idleCycles(6);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial front-end stage directly upstream of the team's parity_checker.
- Deserialises start/data/parity/stop frames from a one-bit line into a parallel word plus its received parity bit.
- Presents the word on a valid/ready output, with the parity verdict computed by an instantiated parity_checker.
- Even parity throughout: XOR of the data bits and the parity bit equals 0 for a good frame.

Parameters:
- WIDTH, 8: number of data bits per frame (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset: synchronous and active-high; one clock domain, no other clock.
- bit_en  input  1  qualifies bit_in; a bit is consumed only on cycles with bit_en=1.
- bit_in  input  1  serial line; idle level 1.
- data_out  output  WIDTH  received data word (bit 0 = first data bit on the line).
- parity_out  output  1  received parity bit.
- parity_ok  output  1  1 when data_out/parity_out have even parity (from parity_checker).
- frame_err  output  1  1 when the held frame's stop bit was 0.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word on cycles with out_valid=1 and out_ready=1.
- overrun  output  1  sticky; a completed frame was dropped because the output register was occupied.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, bit counter=0, shift register=0. Outputs: data_out=0, parity_out=0, frame_err=0, out_valid=0, overrun=0. parity_ok follows combinationally from its inputs, so it reads 1 after reset.
- rst mid-frame discards the partial frame. rst wins over every simultaneous event.
- FSM states, all advancing only on cycles with bit_en=1:
  - IDLE: bit_in=1 stays IDLE. bit_in=0 (start bit) goes to DATA with counter=0.
  - DATA: writes bit_in into shift bit [counter] and increments counter. After the bit with counter=WIDTH-1, goes to PARITY.
  - PARITY: captures the parity bit, goes to STOP.
  - STOP: samples the stop bit and always returns to IDLE.
- bit_en=0 cycles hold all frame state. Arbitrarily long gaps are legal.
- Output load on the STOP edge. The register is free if out_valid=0, or if out_valid=1 and out_ready=1 on that same cycle (simultaneous accept and load is allowed).
  - Free: load data_out, parity_out and frame_err (= ~stop bit), and set out_valid=1. The new word is visible on the cycle after the stop bit is sampled (latency 1 clk from the stop-bit edge).
  - Occupied: drop the frame, set overrun=1, and leave the held word untouched.
- Handshake:
  - out_valid stays 1 and the data stays stable until a cycle with out_ready=1.
  - After acceptance, out_valid=0 on the next cycle unless a new frame loads on that same edge.
  - out_ready is ignored while out_valid=0.
- Frames with frame_err=1 or parity_ok=0 are still delivered. Filtering belongs to the consumer.
- Back-to-back frames: a start bit is accepted on the first bit_en cycle after the stop bit.
- overrun clears only on rst.
- Counter width is clog2(WIDTH)+1 bits, so there is no wrap for any legal WIDTH.

Decomposition:
- Shared package: FSM state encoding (IDLE, DATA, PARITY, STOP, 2 bits) and constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
- One sub-module: the existing parity_checker #(WIDTH), instantiated on data_out/parity_out to drive parity_ok. This module adds no other parity logic.

Test Plan:
- Basic frame. WIDTH=8, out_ready=1, bit_en=1 every cycle. Send start 0, data 0x01 LSB-first, parity 1, stop 1. Required: out_valid=1 for one cycle starting the cycle after the stop sample, with data_out=0x01, parity_out=1, parity_ok=1, frame_err=0.
- Bad parity. Send data 0xF0 with parity 1. Required: data_out=0xF0, parity_ok=0, frame_err=0. Then send 0xF0 with parity 0: parity_ok=1.
- Bad stop. Send data 0xA5, parity 0, stop 0. Required: data_out=0xA5, frame_err=1, out_valid=1.
- Backpressure. Hold out_ready=0 and send 0x11 then 0x22. Required: data_out stays 0x11 and out_valid stays 1; overrun=1 after the second stop bit. Then raise out_ready: 0x11 is accepted, 0x22 never appears, and out_valid=0.
- Gapped input. Repeat the basic frame with bit_en=0 for 3 cycles between every bit and bit_in toggling during the gaps, plus idle 1s before the start bit. Required: result identical to the basic-frame case.
- Reset mid-frame. Pulse rst=1 for one cycle after 4 data bits. Required: out_valid=0, overrun=0, no word delivered. A following full 0x3C frame (parity 0) is received correctly with parity_ok=1.
